// File: rtl/ds1302_pkg.sv
// Shared DS1302 definitions: FSM encoding, command-byte fields and clock register map.
// Used by both the bus master and the responder.
package ds1302_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_RD_DATA,
      ST_WR_DATA,
      ST_DONE
   } state_e;

   typedef enum logic [2:0] {
      SEC, MIN, HOUR, DATE, MONTH, DAY, YEAR, WP_REG
   } clk_reg_e;

   localparam int CMD_RD    = 0;
   localparam int CMD_RAM   = 6;
   localparam int CMD_VALID = 7;
   localparam int WP_BIT    = 7;

   localparam logic [7:0] REG0_RST = 8'h80;

endpackage

// File: rtl/ds1302_sync_edge.sv
// Multi-stage synchronizer with single-cycle rise/fall pulses on the synced level.
module ds1302_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic sysclk,
   input  logic rst,
   input  logic d_in,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   always_comb begin
      sync_d    = sync_q << 1;
      sync_d[0] = d_in;
      prev_d    = sync_q[STAGES-1];
   end

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise = sync_q[STAGES-1] & ~prev_q;
   assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/ds1302_responder.sv
// DS1302-compatible 3-wire target: 8 clock registers plus scratch RAM, single-byte
// read/write commands, and a local port for the timekeeping logic.
module ds1302_responder
   import ds1302_pkg::*;
#(
   parameter int RAM_DEPTH   = 31,
   parameter int SYNC_STAGES = 2
) (
   input  logic       sysclk,
   input  logic       rst,
   input  logic       ds1302_ce,
   input  logic       ds1302_clk,
   inout  wire        ds1302_io,
   input  logic       loc_we,
   input  logic [5:0] loc_addr,
   input  logic [7:0] loc_wdata,
   output logic [7:0] loc_rdata,
   output logic       bus_wr_strb,
   output logic [5:0] bus_wr_addr,
   output logic [7:0] bus_wr_data,
   output logic       proto_err,
   output logic       busy
);

   localparam int RAM_N  = (RAM_DEPTH > 0) ? RAM_DEPTH : 1;
   localparam int RAM_AW = (RAM_N > 1) ? $clog2(RAM_N) : 1;
   // One bit per RAM address that is backed by storage.
   localparam logic [31:0] RAM_MAP = 32'hFFFF_FFFF >> (32 - RAM_DEPTH);

   logic [SYNC_STAGES-1:0] ce_sync_q, ce_sync_d, io_sync_q, io_sync_d;
   logic ce_s, io_s, sclk_rise, sclk_fall;

   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [6:0] rx_q, rx_d;
   logic [5:0] cmd_addr_q, cmd_addr_d;
   logic [7:0] tx_q, tx_d;
   logic       io_oe_q, io_oe_d, io_out_q, io_out_d;
   logic       proto_err_q, proto_err_d, strb_q, strb_d;
   logic [5:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d, loc_rdata_q, loc_rdata_d;
   logic [7:0] clk_q [8];
   logic [7:0] clk_d [8];
   logic [7:0] ram_q [RAM_N];
   logic [7:0] ram_d [RAM_N];

   logic       commit_en;
   logic [5:0] commit_a;
   logic [7:0] commit_data, rx_byte;

   function automatic logic is_mapped(input logic [5:0] a);
      return a[5] ? RAM_MAP[a[4:0]] : (a[4:3] == 2'b00);
   endfunction

   function automatic logic [7:0] read_byte(input logic [5:0] a);
      if (!is_mapped(a)) return 8'h00;
      else if (a[5])     return ram_q[a[RAM_AW-1:0]];
      else               return clk_q[a[2:0]];
   endfunction

   ds1302_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
      .sysclk (sysclk),
      .rst    (rst),
      .d_in   (ds1302_clk),
      .rise   (sclk_rise),
      .fall   (sclk_fall)
   );

   // io uses the same depth as sclk so a sample taken on the rise pulse is aligned.
   always_comb begin
      ce_sync_d    = ce_sync_q << 1;
      ce_sync_d[0] = ds1302_ce;
      io_sync_d    = io_sync_q << 1;
      io_sync_d[0] = ds1302_io;
   end

   assign ce_s    = ce_sync_q[SYNC_STAGES-1];
   assign io_s    = io_sync_q[SYNC_STAGES-1];
   assign rx_byte = {io_s, rx_q};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rx_d        = rx_q;
      cmd_addr_d  = cmd_addr_q;
      tx_d        = tx_q;
      io_oe_d     = io_oe_q;
      io_out_d    = io_out_q;
      proto_err_d = 1'b0;
      strb_d      = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      commit_en   = 1'b0;
      commit_a    = cmd_addr_q;
      commit_data = rx_byte;

      if (!ce_s) begin
         state_d = ST_IDLE;
         io_oe_d = 1'b0;
         cnt_d   = 3'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_CMD;
               cnt_d   = 3'd0;
            end
            ST_CMD: if (sclk_rise) begin
               rx_d  = {io_s, rx_q[6:1]};
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  cmd_addr_d = {rx_byte[CMD_RAM], rx_byte[5:1]};
                  if (!rx_byte[CMD_VALID]) begin
                     proto_err_d = 1'b1;
                     state_d     = ST_DONE;
                  end else if (rx_byte[CMD_RD]) begin
                     tx_d    = read_byte({rx_byte[CMD_RAM], rx_byte[5:1]});
                     state_d = ST_RD_DATA;
                  end else begin
                     state_d = ST_WR_DATA;
                  end
               end
            end
            // io_oe doubles as "first bit already driven" so the 9th fall is seen at cnt 0.
            ST_RD_DATA: if (sclk_fall) begin
               if (io_oe_q && cnt_q == 3'd0) begin
                  io_oe_d = 1'b0;
                  state_d = ST_DONE;
               end else begin
                  io_oe_d  = 1'b1;
                  io_out_d = tx_q[0];
                  tx_d     = {1'b0, tx_q[7:1]};
                  cnt_d    = cnt_q + 3'd1;
               end
            end
            ST_WR_DATA: if (sclk_rise) begin
               rx_d  = {io_s, rx_q[6:1]};
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  state_d = ST_DONE;
                  if (is_mapped(cmd_addr_q) &&
                      (!clk_q[WP_REG][WP_BIT] || cmd_addr_q == 6'(WP_REG))) begin
                     commit_en = 1'b1;
                     strb_d    = 1'b1;
                     wr_addr_d = cmd_addr_q;
                     wr_data_d = rx_byte;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Local write first, bus commit second: on an address collision the bus wins.
   always_comb begin
      clk_d = clk_q;
      ram_d = ram_q;
      if (loc_we && is_mapped(loc_addr)) begin
         if (loc_addr[5]) ram_d[loc_addr[RAM_AW-1:0]] = loc_wdata;
         else             clk_d[loc_addr[2:0]]        = loc_wdata;
      end
      if (commit_en) begin
         if (commit_a[5]) ram_d[commit_a[RAM_AW-1:0]] = commit_data;
         else             clk_d[commit_a[2:0]]        = commit_data;
      end
   end

   assign loc_rdata_d = read_byte(loc_addr);

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         ce_sync_q   <= '0;
         io_sync_q   <= '0;
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         rx_q        <= '0;
         cmd_addr_q  <= '0;
         tx_q        <= '0;
         io_oe_q     <= 1'b0;
         io_out_q    <= 1'b0;
         proto_err_q <= 1'b0;
         strb_q      <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         loc_rdata_q <= '0;
         for (int i = 0; i < 8; i++)     clk_q[i] <= 8'h00;
         clk_q[SEC] <= REG0_RST;
         for (int i = 0; i < RAM_N; i++) ram_q[i] <= 8'h00;
      end else begin
         ce_sync_q   <= ce_sync_d;
         io_sync_q   <= io_sync_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rx_q        <= rx_d;
         cmd_addr_q  <= cmd_addr_d;
         tx_q        <= tx_d;
         io_oe_q     <= io_oe_d;
         io_out_q    <= io_out_d;
         proto_err_q <= proto_err_d;
         strb_q      <= strb_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         loc_rdata_q <= loc_rdata_d;
         clk_q       <= clk_d;
         ram_q       <= ram_d;
      end
   end

   assign ds1302_io   = io_oe_q ? io_out_q : 1'bz;
   assign loc_rdata   = loc_rdata_q;
   assign bus_wr_strb = strb_q;
   assign bus_wr_addr = wr_addr_q;
   assign bus_wr_data = wr_data_q;
   assign proto_err   = proto_err_q;
   assign busy        = (state_q != ST_IDLE);

endmodule
